// File: rtl/perf_counter_bank_pkg.sv
// rtl/perf_counter_bank_pkg.sv - shared constants and decode types for the perf counter bank
package perf_counter_bank_pkg;

    localparam int PERF_CTRL_FREEZE = 0;
    localparam int PERF_CTRL_CLEAR  = 1;

    localparam logic [31:0] PERF_BASE_DEFAULT = 32'hffffffd8;

    typedef enum logic [1:0] {
        SEL_NONE = 2'd0,
        SEL_CNT  = 2'd1,
        SEL_CTRL = 2'd2,
        SEL_OVF  = 2'd3
    } perf_sel_e;

endpackage

// File: rtl/perf_counter_chan.sv
// rtl/perf_counter_chan.sv - one counter channel: qualifier, increment, overflow detect, write/clear priority
// Optional build macro: PERF_SATURATE_EN (hold at all-ones instead of wrapping)
module perf_counter_chan
    import perf_counter_bank_pkg::*;
#(
    parameter int CNT_WIDTH = 32,
    parameter bit EDGE      = 1'b0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 event_in,
    input  logic                 freeze,
    input  logic                 clear,
    input  logic                 wr_en,
    input  logic [CNT_WIDTH-1:0] wr_data,
    output logic [CNT_WIDTH-1:0] count,
    output logic                 ovf_set
);

    logic                 qual;
    logic                 inc;
    logic                 at_max;
    logic [CNT_WIDTH-1:0] count_inc;

    // prev keeps sampling while frozen so unfreezing never sees a stale edge
    if (EDGE) begin : g_edge
        logic prev;
        always_ff @(posedge clk) begin
            if (rst) begin
                prev <= 1'b0;
            end else begin
                prev <= event_in;
            end
        end
        assign qual = event_in & ~prev;
    end else begin : g_level
        assign qual = event_in;
    end

    assign at_max  = &count;
    assign inc     = qual & ~freeze & ~clear & ~wr_en;
    assign ovf_set = inc & at_max;

`ifdef PERF_SATURATE_EN
    assign count_inc = at_max ? count : count + CNT_WIDTH'(1);
`else
    assign count_inc = count + CNT_WIDTH'(1);
`endif

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            count <= '0;
        end else if (wr_en) begin
            count <= wr_data;
        end else if (inc) begin
            count <= count_inc;
        end
    end

endmodule

// File: rtl/perf_counter_bank.sv
// rtl/perf_counter_bank.sv - MMIO-mapped bank of event counters with CTRL and sticky OVF registers
// Optional build macro: PERF_SATURATE_EN (handled inside perf_counter_chan)
module perf_counter_bank
    import perf_counter_bank_pkg::*;
#(
    parameter int                 NUM_CNT   = 10,
    parameter int                 CNT_WIDTH = 32,
    parameter logic [31:0]        BASE_ADDR = PERF_BASE_DEFAULT,
    parameter logic [NUM_CNT-1:0] EDGE_MASK = '0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_CNT-1:0] event_i,
    input  logic               cnt_read,
    input  logic               cnt_write,
    input  logic [31:0]        cnt_addr,
    input  logic [31:0]        cnt_wdata,
    output logic [31:0]        cnt_rdata,
    output logic               cnt_resp,
    output logic               cnt_hit
);

    localparam logic [29:0] CTRL_WORD = 30'(NUM_CNT);
    localparam logic [29:0] OVF_WORD  = 30'(NUM_CNT + 1);

    logic [31:0]          offset;
    logic [29:0]          word;
    perf_sel_e            sel;
    logic                 req;
    logic                 rd_req;
    logic                 ctrl_wr;
    logic                 ovf_wr;
    logic                 clear;
    logic                 freeze;
    logic [NUM_CNT-1:0]   ovf;
    logic [NUM_CNT-1:0]   ovf_evt;
    logic [NUM_CNT-1:0]   ovf_clr;
    logic [NUM_CNT-1:0]   cnt_wr;
    logic [CNT_WIDTH-1:0] counts [NUM_CNT];
    logic [31:0]          rd_val;
    logic                 unused_wdata;

    // Addresses below the base wrap to a huge word index and fall outside the window
    assign offset = cnt_addr - BASE_ADDR;
    assign word   = offset[31:2];

    always_comb begin
        sel = SEL_NONE;
        if (offset[1:0] == 2'b00) begin
            if (word < CTRL_WORD) begin
                sel = SEL_CNT;
            end else if (word == CTRL_WORD) begin
                sel = SEL_CTRL;
            end else if (word == OVF_WORD) begin
                sel = SEL_OVF;
            end
        end
    end

    assign cnt_hit = (sel != SEL_NONE);
    assign req     = (cnt_read | cnt_write) & cnt_hit;
    assign rd_req  = cnt_read & cnt_hit;
    assign ctrl_wr = cnt_write & (sel == SEL_CTRL);
    assign ovf_wr  = cnt_write & (sel == SEL_OVF);
    assign clear   = ctrl_wr & cnt_wdata[PERF_CTRL_CLEAR];
    assign ovf_clr = ovf_wr ? cnt_wdata[NUM_CNT-1:0] : '0;

    assign unused_wdata = ^cnt_wdata;

    always_comb begin
        cnt_wr = '0;
        for (int i = 0; i < NUM_CNT; i++) begin
            cnt_wr[i] = cnt_write && (sel == SEL_CNT) && (word == 30'(i));
        end
    end

    always_comb begin
        rd_val = '0;
        case (sel)
            SEL_CNT: begin
                for (int i = 0; i < NUM_CNT; i++) begin
                    if (word == 30'(i)) begin
                        rd_val = 32'(counts[i]);
                    end
                end
            end
            SEL_CTRL: rd_val[PERF_CTRL_FREEZE] = freeze;
            SEL_OVF:  rd_val = 32'(ovf);
            default:  rd_val = '0;
        endcase
    end

    for (genvar g = 0; g < NUM_CNT; g++) begin : g_chan
        perf_counter_chan #(
            .CNT_WIDTH(CNT_WIDTH),
            .EDGE     (EDGE_MASK[g])
        ) u_chan (
            .clk     (clk),
            .rst     (rst),
            .event_in(event_i[g]),
            .freeze  (freeze),
            .clear   (clear),
            .wr_en   (cnt_wr[g]),
            .wr_data (cnt_wdata[CNT_WIDTH-1:0]),
            .count   (counts[g]),
            .ovf_set (ovf_evt[g])
        );
    end

    // A new overflow outranks a same-cycle W1C; clear_all outranks both
    always_ff @(posedge clk) begin
        if (rst) begin
            freeze    <= 1'b0;
            ovf       <= '0;
            cnt_resp  <= 1'b0;
            cnt_rdata <= '0;
        end else begin
            if (ctrl_wr) begin
                freeze <= cnt_wdata[PERF_CTRL_FREEZE];
            end
            if (clear) begin
                ovf <= '0;
            end else begin
                ovf <= (ovf & ~ovf_clr) | ovf_evt;
            end
            cnt_resp <= req;
            if (rd_req) begin
                cnt_rdata <= rd_val;
            end
        end
    end

endmodule

// File: tb/tb_perf_counter_bank.sv
// tb/tb_perf_counter_bank.sv - directed and random checks of perf_counter_bank against a reference model
module tb_perf_counter_bank;

    localparam int          N     = 8;
    localparam int          W     = 4;
    localparam int          MAXV  = (1 << W) - 1;
    localparam logic [31:0] BASE  = 32'hffffffd8;
    localparam logic [7:0]  EDGE  = 8'b0001_0010;
    localparam logic [31:0] A_CTRL = BASE + 32'(4 * N);
    localparam logic [31:0] A_OVF  = BASE + 32'(4 * (N + 1));
`ifdef PERF_SATURATE_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic [7:0]  event_i;
    logic        cnt_read;
    logic        cnt_write;
    logic [31:0] cnt_addr;
    logic [31:0] cnt_wdata;
    logic [31:0] cnt_rdata;
    logic        cnt_resp;
    logic        cnt_hit;

    int n_checks = 0;
    int n_fail   = 0;

    int          m_cnt [N];
    logic [7:0]  m_ovf;
    logic [7:0]  m_prev;
    logic        m_frz;
    logic [31:0] m_rdata;
    logic        m_resp;

    perf_counter_bank #(
        .NUM_CNT  (N),
        .CNT_WIDTH(W),
        .BASE_ADDR(BASE),
        .EDGE_MASK(EDGE)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .event_i  (event_i),
        .cnt_read (cnt_read),
        .cnt_write(cnt_write),
        .cnt_addr (cnt_addr),
        .cnt_wdata(cnt_wdata),
        .cnt_rdata(cnt_rdata),
        .cnt_resp (cnt_resp),
        .cnt_hit  (cnt_hit)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] a_cnt(input int i);
        return BASE + 32'(4 * i);
    endfunction

    function automatic bit m_hit(input logic [31:0] a);
        longint la;
        la = longint'(a);
        return (a[1:0] == 2'b00) && (la >= longint'(BASE)) && (la < longint'(BASE) + 4 * (N + 2));
    endfunction

    function automatic int m_idx(input logic [31:0] a);
        return int'((longint'(a) - longint'(BASE)) / 4);
    endfunction

    function automatic logic [31:0] m_read(input int idx);
        if (idx < N) return 32'(m_cnt[idx]);
        if (idx == N) return {31'b0, m_frz};
        return {24'b0, m_ovf};
    endfunction

    task automatic model_step(input bit r, input bit rd, input bit wr, input logic [31:0] a,
                              input logic [31:0] wd, input logic [7:0] ev);
        bit         hit;
        int         idx;
        bit         clr;
        bit         q;
        logic [7:0] new_ov;
        if (r) begin
            for (int i = 0; i < N; i++) m_cnt[i] = 0;
            m_ovf = '0; m_prev = '0; m_frz = 1'b0; m_rdata = '0; m_resp = 1'b0;
            return;
        end
        hit    = m_hit(a);
        idx    = hit ? m_idx(a) : -1;
        m_resp = (rd || wr) && hit;
        if (rd && hit) m_rdata = m_read(idx);
        clr    = wr && hit && (idx == N) && wd[1];
        new_ov = '0;
        for (int i = 0; i < N; i++) begin
            q = EDGE[i] ? (ev[i] && !m_prev[i]) : ev[i];
            if (clr) begin
                m_cnt[i] = 0;
            end else if (wr && hit && idx == i) begin
                m_cnt[i] = int'(wd) & MAXV;
            end else if (q && !m_frz) begin
                if (m_cnt[i] == MAXV) begin
                    new_ov[i] = 1'b1;
                    m_cnt[i]  = SAT ? MAXV : 0;
                end else begin
                    m_cnt[i] = m_cnt[i] + 1;
                end
            end
        end
        m_prev = ev;
        if (clr) begin
            m_ovf = '0;
        end else begin
            if (wr && hit && idx == N + 1) m_ovf = m_ovf & ~wd[7:0];
            m_ovf = m_ovf | new_ov;
        end
        if (wr && hit && idx == N) m_frz = wd[0];
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step(input bit r, input bit rd, input bit wr, input logic [31:0] a,
                        input logic [31:0] wd, input logic [7:0] ev);
        rst = r; cnt_read = rd; cnt_write = wr; cnt_addr = a; cnt_wdata = wd; event_i = ev;
        #1;
        check("hit", 32'(cnt_hit), 32'(m_hit(a)));
        @(posedge clk);
        model_step(r, rd, wr, a, wd, ev);
        #1;
        check("resp", 32'(cnt_resp), 32'(m_resp));
        check("rdata", cnt_rdata, m_rdata);
    endtask

    task automatic rd_expect(input string tag, input logic [31:0] a, input logic [31:0] e,
                             input logic [7:0] ev);
        step(1'b0, 1'b1, 1'b0, a, 32'h0, ev);
        check({tag, "_resp"}, 32'(cnt_resp), 32'h1);
        check(tag, cnt_rdata, e);
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [7:0] ev);
        step(1'b0, 1'b0, 1'b1, a, d, ev);
    endtask

    task automatic idle(input int n, input logic [7:0] ev);
        for (int k = 0; k < n; k++) step(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, ev);
    endtask

    initial begin
        logic [31:0] ra;
        logic [31:0] rw;
        int          sel;
        rst = 1'b1; cnt_read = 1'b0; cnt_write = 1'b0; cnt_addr = '0; cnt_wdata = '0; event_i = '0;

        step(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 8'h00);
        step(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 8'h00);
        check("rst_resp", 32'(cnt_resp), 32'h0);
        check("rst_rdata", cnt_rdata, 32'h0);
        for (int i = 0; i < N; i++) rd_expect("rst_cnt", a_cnt(i), 32'h0, 8'h00);
        rd_expect("rst_ovf", A_OVF, 32'h0, 8'h00);
        rd_expect("rst_ctrl", A_CTRL, 32'h0, 8'h00);

        idle(5, 8'h01);
        rd_expect("level_cnt0", a_cnt(0), 32'd5, 8'h00);
        check("resp_one_cycle", 32'(cnt_resp), 32'h1);
        idle(1, 8'h00);
        check("resp_drops", 32'(cnt_resp), 32'h0);

        idle(4, 8'h02); idle(2, 8'h00); idle(3, 8'h02);
        rd_expect("edge_cnt1", a_cnt(1), 32'd2, 8'h00);

        idle(17, 8'h04);
        rd_expect("wrap_cnt2", a_cnt(2), SAT ? 32'd15 : 32'd1, 8'h00);
        rd_expect("ovf_set", A_OVF, 32'h4, 8'h00);
        wr(A_OVF, 32'h4, 8'h00);
        rd_expect("ovf_w1c", A_OVF, 32'h0, 8'h00);

        idle(1, 8'h02);
        wr(A_CTRL, 32'h1, 8'h02);
        idle(9, 8'h03);
        rd_expect("ctrl_frozen", A_CTRL, 32'h1, 8'h03);
        wr(A_CTRL, 32'h0, 8'h03);
        idle(2, 8'h02);
        rd_expect("freeze_cnt0", a_cnt(0), 32'd5, 8'h00);
        rd_expect("freeze_cnt1", a_cnt(1), 32'd3, 8'h00);

        wr(a_cnt(3), 32'h7, 8'h08);
        rd_expect("wr_beats_inc", a_cnt(3), 32'h7, 8'h00);

        idle(16, 8'h04);
        rd_expect("ovf_again", A_OVF, 32'h4, 8'h00);
        wr(A_CTRL, 32'h2, 8'hff);
        for (int i = 0; i < N; i++) rd_expect("clear_cnt", a_cnt(i), 32'h0, 8'h00);
        rd_expect("clear_ovf", A_OVF, 32'h0, 8'h00);
        rd_expect("clear_ctrl", A_CTRL, 32'h0, 8'h00);

        step(1'b0, 1'b1, 1'b1, a_cnt(0), 32'h9, 8'h00);
        check("rw_prewrite", cnt_rdata, 32'h0);
        rd_expect("rw_postwrite", a_cnt(0), 32'h9, 8'h00);

        step(1'b0, 1'b1, 1'b0, BASE + 32'(4 * (N + 2)), 32'h0, 8'h00);
        check("miss_hit", 32'(cnt_hit), 32'h0);
        check("miss_resp0", 32'(cnt_resp), 32'h0);
        for (int k = 0; k < 3; k++) begin
            idle(1, 8'h00);
            check("miss_resp", 32'(cnt_resp), 32'h0);
        end
        step(1'b0, 1'b1, 1'b1, BASE - 32'd4, 32'h3, 8'h00);
        check("below_resp", 32'(cnt_resp), 32'h0);
        step(1'b0, 1'b1, 1'b0, BASE + 32'd2, 32'h0, 8'h00);
        check("unaligned_resp", 32'(cnt_resp), 32'h0);

        step(1'b1, 1'b1, 1'b0, a_cnt(0), 32'h0, 8'h00);
        check("rst_drops_resp", 32'(cnt_resp), 32'h0);
        idle(1, 8'h12);
        rd_expect("first_edge_cnt1", a_cnt(1), 32'd1, 8'h12);
        rd_expect("first_edge_cnt4", a_cnt(4), 32'd1, 8'h12);
        rd_expect("after_rst_cnt0", a_cnt(0), 32'd0, 8'h00);

        for (int it = 0; it < 600; it++) begin
            sel = int'($urandom_range(0, 11));
            rw  = $urandom;
            if (sel < N) ra = a_cnt(sel);
            else if (sel == N) begin
                ra = A_CTRL;
                rw[1] = ($urandom_range(0, 7) == 0);
            end else if (sel == N + 1) ra = A_OVF;
            else if (sel == N + 2) ra = BASE - 32'd4;
            else ra = a_cnt(int'($urandom_range(0, N - 1))) + 32'd1;
            step($urandom_range(0, 149) == 0, $urandom_range(0, 2) == 0, $urandom_range(0, 3) == 0,
                 ra, rw, 8'($urandom));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
